// File: rtl/biu_constants_pkg.sv
// Shared bus-interface-unit encodings for transfer size, burst type and protection.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011,
        QWORD = 3'b100
    } biu_size_t;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } biu_type_t;

    typedef logic [2:0] biu_prot_t;

    localparam biu_prot_t PROT_DATA        = 3'b000;
    localparam biu_prot_t PROT_INSTRUCTION = 3'b100;
    localparam biu_prot_t PROT_USER        = 3'b000;
    localparam biu_prot_t PROT_PRIVILEGED  = 3'b010;
    localparam biu_prot_t PROT_NONSECURE   = 3'b000;
    localparam biu_prot_t PROT_SECURE      = 3'b001;

endpackage

// File: rtl/riscv_ifq_pkg.sv
// Types and helpers for the instruction fetch queue (optional bypass: RISCV_IFQ_BYPASS_EN).
package riscv_ifq_pkg;
    import biu_constants_pkg::*;

    localparam int IFQ_XLEN_MAX = 64;

    localparam logic [1:0] PRV_U = 2'b00;
    localparam logic [1:0] PRV_S = 2'b01;
    localparam logic [1:0] PRV_M = 2'b11;

    // Sized for the widest XLEN; narrower builds use the low bits of each field.
    typedef struct packed {
        logic [IFQ_XLEN_MAX-1:0] parcel;
        logic [IFQ_XLEN_MAX-1:0] pc;
        logic                    err;
    } ifq_entry_t;

    function automatic biu_prot_t ifq_prot(input logic [1:0] prv);
        return PROT_INSTRUCTION | ((prv == PRV_U) ? PROT_USER : PROT_PRIVILEGED);
    endfunction

endpackage

// File: rtl/riscv_ifq_fifo.sv
// Parametrised-width circular FIFO with synchronous clear and level count.
module riscv_ifq_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign q_o     = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push_i & ~clr_i & (~full_o | pop_i);
    assign do_pop  = pop_i  & ~clr_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= d_i;
    end

endmodule

// File: rtl/riscv_ifetch_queue.sv
// Pipelined cacheless instruction fetch: up to DEPTH sequential fetches in flight,
// responses buffered with PC and error tag. Zero-latency bypass under RISCV_IFQ_BYPASS_EN.
module riscv_ifetch_queue
    import biu_constants_pkg::*;
    import riscv_ifq_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PLEN        = XLEN,
    parameter int DEPTH       = 4,
    parameter int BIUTAG_SIZE = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   if_flush_i,
    input  logic [XLEN-1:0]        if_nxt_pc_i,
    input  logic                   if_rdy_i,
    output logic                   if_parcel_valid_o,
    output logic [XLEN-1:0]        if_parcel_o,
    output logic [XLEN-1:0]        if_parcel_pc_o,
    output logic                   if_parcel_error_o,

    input  logic [1:0]             st_prv_i,

    output logic                   biu_stb_o,
    input  logic                   biu_stb_ack_i,
    output logic [PLEN-1:0]        biu_adri_o,
    output biu_size_t              biu_size_o,
    output biu_type_t              biu_type_o,
    output biu_prot_t              biu_prot_o,
    output logic [BIUTAG_SIZE-1:0] biu_tagi_o,
    input  logic [XLEN-1:0]        biu_q_i,
    input  logic                   biu_ack_i,
    input  logic                   biu_err_i
);

    localparam int AW    = $clog2(DEPTH);
    localparam int EW    = 2*XLEN + 1;
    localparam int BYTES = XLEN / 8;
    localparam int LSB   = $clog2(BYTES);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            active_q, active_d;
    logic [AW:0]     discard_q, discard_d;

    logic [XLEN-1:0] pc_aligned;
    logic [AW+1:0]   credit_used;
    logic            credit_ok;
    logic            accept, resp, resp_keep;
    logic [AW:0]     out_next;

    logic [XLEN-1:0] pcf_head;
    logic            pcf_full, pcf_empty;
    logic [AW:0]     pcf_level;

    logic [EW-1:0]   resp_entry, dq_head, head_entry;
    logic            dq_full, dq_empty, dq_push, dq_pop;
    logic [AW:0]     dq_level;
    logic            parcel_valid;

    assign pc_aligned = {fetch_pc_q[XLEN-1:LSB], {LSB{1'b0}}};

    // The PC FIFO level is the number of requests accepted but not yet answered.
    assign credit_used = {1'b0, pcf_level} + {1'b0, dq_level};
    assign credit_ok   = (credit_used < (AW+2)'(DEPTH)) & ~pcf_full & ~dq_full;

    // A late ack racing a flush still counts: the request was on the bus that cycle.
    assign accept    = biu_stb_ack_i & active_q & credit_ok;
    assign resp      = (biu_ack_i | biu_err_i) & ~pcf_empty;
    assign resp_keep = resp & ~if_flush_i & (discard_q == '0);
    assign out_next  = pcf_level + (AW+1)'(accept) - (AW+1)'(resp);

    assign resp_entry = {biu_q_i, pcf_head, biu_err_i};

    assign biu_stb_o  = active_q & ~if_flush_i & credit_ok;
    assign biu_adri_o = PLEN'(pc_aligned);
    assign biu_type_o = SINGLE;
    assign biu_prot_o = ifq_prot(st_prv_i);
    assign biu_tagi_o = '0;

    generate
        if (XLEN == 32) begin : g_size_word
            assign biu_size_o = WORD;
        end else begin : g_size_dword
            assign biu_size_o = DWORD;
        end
    endgenerate

    riscv_ifq_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (1'b0),
        .push_i  (accept),
        .pop_i   (resp),
        .d_i     (pc_aligned),
        .q_o     (pcf_head),
        .full_o  (pcf_full),
        .empty_o (pcf_empty),
        .level_o (pcf_level)
    );

    riscv_ifq_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_data_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (if_flush_i),
        .push_i  (dq_push),
        .pop_i   (dq_pop),
        .d_i     (resp_entry),
        .q_o     (dq_head),
        .full_o  (dq_full),
        .empty_o (dq_empty),
        .level_o (dq_level)
    );

    assign dq_pop = ~dq_empty & if_rdy_i & ~if_flush_i;

`ifdef RISCV_IFQ_BYPASS_EN
    logic bypass;

    // An empty queue lets a live response through combinationally; if taken, it is never stored.
    assign bypass       = resp_keep & dq_empty;
    assign dq_push      = resp_keep & ~(bypass & if_rdy_i);
    assign head_entry   = dq_empty ? resp_entry : dq_head;
    assign parcel_valid = ~dq_empty | bypass;
`else
    assign dq_push      = resp_keep;
    assign head_entry   = dq_head;
    assign parcel_valid = ~dq_empty;
`endif

    assign if_parcel_valid_o = parcel_valid;
    assign if_parcel_o       = parcel_valid ? head_entry[EW-1 -: XLEN]   : '0;
    assign if_parcel_pc_o    = parcel_valid ? head_entry[XLEN -: XLEN]   : '0;
    assign if_parcel_error_o = parcel_valid & head_entry[0];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        active_d   = active_q;
        discard_d  = discard_q;
        if (if_flush_i) begin
            fetch_pc_d = if_nxt_pc_i;
            active_d   = 1'b1;
            discard_d  = out_next;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + XLEN'(BYTES);
            if (resp && (discard_q != '0)) discard_d = discard_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= '0;
            active_q   <= 1'b0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            active_q   <= active_d;
            discard_q  <= discard_d;
        end
    end

endmodule

// File: tb/tb_riscv_ifetch_queue.sv
// Randomised scoreboard bench for riscv_ifetch_queue; the reference tracks in-flight
// requests as a queue of PCs marked stale by redirects.
module tb_riscv_ifetch_queue;
    import biu_constants_pkg::*;
    import riscv_ifq_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef RISCV_IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             if_flush;
    logic [XLEN-1:0]  if_nxt_pc;
    logic             if_rdy;
    logic             if_parcel_valid;
    logic [XLEN-1:0]  if_parcel;
    logic [XLEN-1:0]  if_parcel_pc;
    logic             if_parcel_error;
    logic [1:0]       st_prv;
    logic             biu_stb;
    logic             biu_stb_ack;
    logic [XLEN-1:0]  biu_adri;
    biu_size_t        biu_size;
    biu_type_t        biu_type;
    biu_prot_t        biu_prot;
    logic [0:0]       biu_tagi;
    logic [XLEN-1:0]  biu_q;
    logic             biu_ack;
    logic             biu_err;

    always #5 clk = ~clk;

    riscv_ifetch_queue #(
        .XLEN(XLEN), .PLEN(XLEN), .DEPTH(DEPTH), .BIUTAG_SIZE(1)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .if_flush_i        (if_flush),
        .if_nxt_pc_i       (if_nxt_pc),
        .if_rdy_i          (if_rdy),
        .if_parcel_valid_o (if_parcel_valid),
        .if_parcel_o       (if_parcel),
        .if_parcel_pc_o    (if_parcel_pc),
        .if_parcel_error_o (if_parcel_error),
        .st_prv_i          (st_prv),
        .biu_stb_o         (biu_stb),
        .biu_stb_ack_i     (biu_stb_ack),
        .biu_adri_o        (biu_adri),
        .biu_size_o        (biu_size),
        .biu_type_o        (biu_type),
        .biu_prot_o        (biu_prot),
        .biu_tagi_o        (biu_tagi),
        .biu_q_i           (biu_q),
        .biu_ack_i         (biu_ack),
        .biu_err_i         (biu_err)
    );

    typedef struct {
        logic [XLEN-1:0] pc;
        bit              stale;
    } req_t;

    typedef struct {
        logic [XLEN-1:0] tgt;
        bit              do_flush;
        int              cycles;
        int              p_sack;
        int              p_resp;
        int              p_rdy;
        int              p_flush;
    } phase_t;

    req_t            pend_q[$];
    ifq_entry_t      exp_q[$];
    int              tests = 0;
    int              fails = 0;
    bit              fresh_only = 1'b0;
    bit              model_active = 1'b0;
    logic [XLEN-1:0] model_pc = '0;
    phase_t          phases[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit chance(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    function automatic logic [XLEN-1:0] rand_target();
        logic [XLEN-1:0] t;
        case ($urandom_range(3))
            0: t = 32'h0000_0100;
            1: t = 32'h0000_0200;
            2: t = 32'hFFFF_FFF8;
            default: t = $urandom & 32'hFFFF_FFFC;
        endcase
        return t;
    endfunction

    // One bus cycle: check strobe/address against the model, then choose and drive inputs.
    task automatic do_cycle(input phase_t ph, input bit force_flush);
        bit              exp_stb, fl, sack, rsp, e;
        req_t            r;
        ifq_entry_t      ent;
        logic [XLEN-1:0] data, tgt;
        @(negedge clk);
        if_flush    = 1'b0;
        biu_stb_ack = 1'b0;
        biu_ack     = 1'b0;
        biu_err     = 1'b0;
        #1;
        exp_stb = model_active && ((pend_q.size() + exp_q.size()) < DEPTH);
        check("stb", 64'(biu_stb), 64'(exp_stb));
        if (exp_stb) check("adr", 64'(biu_adri), 64'(model_pc));

        fl   = force_flush || chance(ph.p_flush);
        tgt  = force_flush ? ph.tgt : rand_target();
        sack = exp_stb && chance(ph.p_sack);
        rsp  = (pend_q.size() > 0) && chance(ph.p_resp);
        fresh_only = 1'b0;
        if (rsp) begin
            r    = pend_q.pop_front();
            data = $urandom;
            e    = chance(8);
            biu_q   = data;
            biu_ack = ~e;
            biu_err = e;
            if (!r.stale && !fl) begin
                fresh_only = (exp_q.size() == 0);
                ent.parcel = 64'(data);
                ent.pc     = 64'(r.pc);
                ent.err    = e;
                exp_q.push_back(ent);
            end
        end
        if (sack) begin
            r.pc    = model_pc;
            r.stale = fl;
            pend_q.push_back(r);
            model_pc = model_pc + 32'd4;
        end
        if (fl) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            model_pc     = tgt;
            model_active = 1'b1;
            if_nxt_pc    = tgt;
            if_flush     = 1'b1;
        end
        biu_stb_ack = sack;
        if_rdy      = chance(ph.p_rdy);
    endtask

    // Monitor: compares the presented head against the scoreboard on every handshake.
    initial begin
        ifq_entry_t e;
        bit         exp_valid;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n === 1'b1 && if_flush === 1'b0) begin
                exp_valid = fresh_only ? BYP : (exp_q.size() > 0);
                check("valid", 64'(if_parcel_valid), 64'(exp_valid));
                if (if_parcel_valid && if_rdy) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_parcel: got pc 0x%0h expected none", if_parcel_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("parcel_pc", 64'(if_parcel_pc), e.pc);
                        check("parcel", 64'(if_parcel), e.parcel);
                        check("parcel_err", 64'(if_parcel_error), 64'(e.err));
                        $display("[TB] parcel pc=0x%08h data=0x%08h err=%0d", if_parcel_pc, if_parcel, if_parcel_error);
                    end
                end
            end
        end
    end

    initial begin
        phase_t drain;
        int     n;
        //             tgt           flush cyc   sack resp rdy flush
        phases[0] = '{32'h0000_0100, 1'b1, 30,   100, 100, 100, 0};
        phases[1] = '{32'h0000_0300, 1'b1, 20,   100, 100, 0,   0};
        phases[2] = '{32'h0000_0000, 1'b0, 10,   100, 100, 100, 0};
        phases[3] = '{32'hFFFF_FFF8, 1'b1, 20,   100, 100, 100, 0};
        phases[4] = '{32'h0000_0200, 1'b1, 3000, 70,  50,  70,  4};

        rst_n = 1'b0; if_flush = 1'b0; if_nxt_pc = '0; if_rdy = 1'b0;
        st_prv = 2'b11; biu_stb_ack = 1'b0; biu_q = '0; biu_ack = 1'b0; biu_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 64'(if_parcel_valid), 64'd0);
        check("rst_parcel", 64'(if_parcel), 64'd0);
        check("rst_pc", 64'(if_parcel_pc), 64'd0);
        check("rst_err", 64'(if_parcel_error), 64'd0);
        check("rst_stb", 64'(biu_stb), 64'd0);
        check("rst_adr", 64'(biu_adri), 64'd0);
        check("tag", 64'(biu_tagi), 64'd0);
        check("size", 64'(biu_size), 64'(3'b010));
        check("type", 64'(biu_type), 64'(3'b000));
        check("prot_m", 64'(biu_prot), 64'(3'b110));
        st_prv = 2'b00;
        #1;
        check("prot_u", 64'(biu_prot), 64'(3'b100));
        st_prv = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (phases[p]) begin
            for (int c = 0; c < phases[p].cycles; c++)
                do_cycle(phases[p], phases[p].do_flush && (c == 0));
        end

        drain = '{32'h0, 1'b0, 1, 0, 100, 100, 0};
        n = 0;
        while ((pend_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
            do_cycle(drain, 1'b0);
            n++;
        end
        do_cycle(drain, 1'b0);
        do_cycle(drain, 1'b0);
        check("drained", 64'(pend_q.size() + exp_q.size()), 64'd0);

        @(negedge clk);
        #5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
